// File: rtl/match_result_ctrl.sv
// match_result_ctrl: Pong match referee that scores points, decides the result and gates restart.
module match_result_ctrl #(
    parameter int SCORE_W     = 4,
    parameter int RND_W       = 5,
    parameter int WIN_SCORE   = 5,
    parameter int MAX_ROUNDS  = 9,
    parameter int HOLD_FRAMES = 120
) (
    input  logic               clk_d,
    input  logic               rst_n,
    input  logic               start,
    input  logic               p1_point,
    input  logic               p2_point,
    input  logic               frame_tick,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic [RND_W-1:0]   rounds_played,
    output logic               playing,
    output logic               game_over,
    output logic               player1_win,
    output logic               player2_win,
    output logic               draw,
    output logic               restart_ok
);
    if (WIN_SCORE < 1 || WIN_SCORE > 2**SCORE_W - 1) begin : g_bad_win
        $error("WIN_SCORE does not fit in SCORE_W bits");
    end
    if (MAX_ROUNDS < 1 || MAX_ROUNDS > 2**RND_W - 1) begin : g_bad_rounds
        $error("MAX_ROUNDS does not fit in RND_W bits");
    end
    if (HOLD_FRAMES < 1 || HOLD_FRAMES > 255) begin : g_bad_hold
        $error("HOLD_FRAMES must be 1..255");
    end

    typedef enum logic [1:0] {IDLE, PLAY, RESULT} state_t;

    localparam logic [SCORE_W:0] WIN  = (SCORE_W+1)'(WIN_SCORE);
    localparam logic [RND_W:0]   MAXR = (RND_W+1)'(MAX_ROUNDS);
    localparam logic [7:0]       HOLD = 8'(HOLD_FRAMES);

    state_t             state, state_n;
    logic [SCORE_W:0]   p1_sum, p2_sum;
    logic [RND_W:0]     rnd_sum;
    logic [SCORE_W-1:0] p1_n, p2_n;
    logic [RND_W-1:0]   rnd_n;
    logic [7:0]         hold, hold_n;
    logic               w1_n, w2_n, dr_n, done;

    // Next-state, next-score and result decision from the updated (post-pulse) counts
    always_comb begin
        state_n = state;
        p1_n    = p1_score;
        p2_n    = p2_score;
        rnd_n   = rounds_played;
        hold_n  = hold;
        w1_n    = player1_win;
        w2_n    = player2_win;
        dr_n    = draw;
        p1_sum  = {1'b0, p1_score} + (SCORE_W+1)'(p1_point);
        p2_sum  = {1'b0, p2_score} + (SCORE_W+1)'(p2_point);
        rnd_sum = {1'b0, rounds_played} + (RND_W+1)'(p1_point) + (RND_W+1)'(p2_point);
        done    = p1_sum >= WIN || p2_sum >= WIN || rnd_sum >= MAXR;
        case (state)
            IDLE: state_n = start ? PLAY : IDLE;
            PLAY: begin
                p1_n  = p1_sum[SCORE_W-1:0];
                p2_n  = p2_sum[SCORE_W-1:0];
                rnd_n = rnd_sum[RND_W-1:0];
                if (done) begin
                    state_n = RESULT;
                    hold_n  = '0;
                    w1_n    = p1_sum > p2_sum;
                    w2_n    = p2_sum > p1_sum;
                    dr_n    = p1_sum == p2_sum;
                end
            end
            RESULT: begin
                if (start && restart_ok) begin
                    state_n = PLAY;
                    p1_n    = '0;
                    p2_n    = '0;
                    rnd_n   = '0;
                    hold_n  = '0;
                    w1_n    = 1'b0;
                    w2_n    = 1'b0;
                    dr_n    = 1'b0;
                end else if (frame_tick && hold != HOLD) begin
                    hold_n = hold + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and every output register; reset clears the match immediately
    always_ff @(posedge clk_d or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            p1_score      <= '0;
            p2_score      <= '0;
            rounds_played <= '0;
            hold          <= '0;
            playing       <= 1'b0;
            game_over     <= 1'b0;
            player1_win   <= 1'b0;
            player2_win   <= 1'b0;
            draw          <= 1'b0;
            restart_ok    <= 1'b0;
        end else begin
            state         <= state_n;
            p1_score      <= p1_n;
            p2_score      <= p2_n;
            rounds_played <= rnd_n;
            hold          <= hold_n;
            playing       <= state_n == PLAY;
            game_over     <= state_n == RESULT;
            player1_win   <= w1_n;
            player2_win   <= w2_n;
            draw          <= dr_n;
            restart_ok    <= state_n == RESULT && hold_n == HOLD;
        end
    end
endmodule

// File: tb/tb_match_result_ctrl.sv
// tb_match_result_ctrl: directed plus randomized checks of the match referee against a score-keeping model.
module tb_match_result_ctrl;
    localparam int SW = 4, RW = 5, WIN = 5, MAXR = 9, HOLD = 120;

    logic clk_d = 1'b0, rst_n = 1'b0;
    logic start = 1'b0, p1_point = 1'b0, p2_point = 1'b0, frame_tick = 1'b0;
    logic [SW-1:0] p1_score, p2_score;
    logic [RW-1:0] rounds_played;
    logic playing, game_over, player1_win, player2_win, draw, restart_ok;

    int checks = 0, errors = 0;
    int m1, m2, mr, mh, mres;
    bit mact, mover;

    match_result_ctrl #(
        .SCORE_W(SW), .RND_W(RW), .WIN_SCORE(WIN), .MAX_ROUNDS(MAXR), .HOLD_FRAMES(HOLD)
    ) dut (
        .clk_d(clk_d), .rst_n(rst_n), .start(start), .p1_point(p1_point), .p2_point(p2_point),
        .frame_tick(frame_tick), .p1_score(p1_score), .p2_score(p2_score),
        .rounds_played(rounds_played), .playing(playing), .game_over(game_over),
        .player1_win(player1_win), .player2_win(player2_win), .draw(draw), .restart_ok(restart_ok)
    );

    always #5 clk_d = ~clk_d;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int a, input int b, input int r, input bit pl,
                                       input bit go, input bit w1, input bit w2, input bit d, input bit ro);
        return {13'b0, 4'(a), 4'(b), 5'(r), pl, go, w1, w2, d, ro};
    endfunction

    function automatic logic [31:0] obs();
        return {13'b0, p1_score, p2_score, rounds_played, playing, game_over,
                player1_win, player2_win, draw, restart_ok};
    endfunction

    function automatic logic [31:0] expv();
        return pk(m1, m2, mr, mact, mover, mover && mres == 1, mover && mres == 2,
                  mover && mres == 3, mover && mh == HOLD);
    endfunction

    task automatic model_clear();
        m1 = 0; m2 = 0; mr = 0; mh = 0; mres = 0; mact = 0; mover = 0;
    endtask

    task automatic model_step(input bit s, input bit a, input bit b, input bit t);
        if (mact) begin
            m1 += int'(a); m2 += int'(b); mr += int'(a) + int'(b);
            if (m1 >= WIN || m2 >= WIN || mr >= MAXR) begin
                mact = 0; mover = 1; mh = 0;
                mres = (m1 > m2) ? 1 : (m2 > m1) ? 2 : 3;
            end
        end else if (mover) begin
            if (s && mh == HOLD) begin
                model_clear();
                mact = 1;
            end else if (t && mh < HOLD) mh++;
        end else if (s) mact = 1;
    endtask

    task automatic cyc(input bit s, input bit a, input bit b, input bit t, input string tag);
        @(negedge clk_d);
        start = s; p1_point = a; p2_point = b; frame_tick = t;
        @(posedge clk_d);
        #1;
        model_step(s, a, b, t);
        check(tag, obs(), expv());
        start = 0; p1_point = 0; p2_point = 0; frame_tick = 0;
    endtask

    task automatic do_reset();
        @(negedge clk_d);
        #2 rst_n = 1'b0;
        #1 check("async_rst", obs(), 32'd0);
        model_clear();
        @(negedge clk_d);
        rst_n = 1'b1;
    endtask

    task automatic hold_and_restart();
        repeat (HOLD) cyc(0, 0, 0, 1, "hold");
        cyc(1, 0, 0, 0, "restart");
    endtask

    initial begin
        model_clear();
        repeat (2) @(negedge clk_d);
        check("reset", obs(), 32'd0);
        rst_n = 1'b1;
        cyc(0, 1, 1, 0, "idle_pts");
        cyc(1, 0, 0, 0, "start");
        repeat (3) cyc(0, 1, 0, 0, "pre_rst");
        check("p1_3", obs(), pk(3, 0, 3, 1, 0, 0, 0, 0, 0));
        do_reset();
        cyc(0, 1, 0, 0, "post_rst_pt");
        check("post_rst", obs(), 32'd0);
        cyc(1, 1, 0, 0, "start_pt");
        repeat (5) cyc(0, 1, 0, 0, "p1_run");
        check("p1_win", obs(), pk(5, 0, 5, 0, 1, 1, 0, 0, 0));
        repeat (3) cyc(0, 1, 0, 0, "res_pt");
        cyc(1, 0, 0, 0, "early_start");
        check("frozen", obs(), pk(5, 0, 5, 0, 1, 1, 0, 0, 0));
        repeat (HOLD - 1) cyc(0, 0, 0, 1, "hold");
        cyc(1, 0, 0, 0, "start_119");
        check("hold_119", obs(), pk(5, 0, 5, 0, 1, 1, 0, 0, 0));
        cyc(0, 0, 0, 1, "tick_120");
        check("restart_ok", obs(), pk(5, 0, 5, 0, 1, 1, 0, 0, 1));
        cyc(1, 1, 0, 0, "restart");
        check("restarted", obs(), pk(0, 0, 0, 1, 0, 0, 0, 0, 0));
        repeat (4) begin
            cyc(0, 1, 0, 0, "alt1");
            cyc(0, 0, 1, 0, "alt2");
        end
        cyc(0, 1, 1, 0, "both");
        check("draw", obs(), pk(5, 5, 10, 0, 1, 0, 0, 1, 0));
        hold_and_restart();
        repeat (4) begin
            cyc(0, 1, 0, 0, "alt1");
            cyc(0, 0, 1, 0, "alt2");
        end
        check("r8", obs(), pk(4, 4, 8, 1, 0, 0, 0, 0, 0));
        cyc(0, 0, 1, 0, "p2_last");
        check("p2_win", obs(), pk(4, 5, 9, 0, 1, 0, 1, 0, 0));
        hold_and_restart();
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            else cyc($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
                     $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, "rand");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
